bit_scan_unit: RTL and testbench

- Parametrised, sequential bit-transform unit; the multi-cycle successor to our 4-bit combinational in→out transform test block.
- Takes a WIDTH-bit operand and a mode under a start/busy/done handshake, scans the operand one bit per cycle (MSB first), and presents a held result.
- Modes: bit reverse, population count, leading-zero count, parity.
- Used as a small multi-cycle execution unit in the CO project datapath and as a handshake exercise for benches.

---
 rtl/bit_scan_pkg.sv | 18 +
 rtl/bit_scan_unit.sv | 123 ++++++++++++
 tb/tb_bit_scan_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bit_scan_pkg.sv
// bit_scan_pkg
//   Shared constants for bit_scan_unit: operation mode encodings and the
//   FSM state type.
package bit_scan_pkg;

    // Operation select, driven on the mode input
    localparam logic [1:0] MODE_REV = 2'b00;  // bit reverse
    localparam logic [1:0] MODE_POP = 2'b01;  // population count
    localparam logic [1:0] MODE_CLZ = 2'b10;  // leading-zero count
    localparam logic [1:0] MODE_PAR = 2'b11;  // parity

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage : bit_scan_pkg

// File: rtl/bit_scan_unit.sv
// bit_scan_unit
//   Multi-cycle bit-transform unit. An operand is accepted under a
//   start/busy/done handshake, scanned one bit per cycle MSB first, and the
//   result is presented on out and held until the next completion.
//
// Parameters
//   WIDTH  operand/result width, legal range 2..32
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   request, accepted only while busy=0 (IDLE or DONE)
//   mode   in   2'b00 REV, 2'b01 POP, 2'b10 CLZ, 2'b11 PAR
//   in     in   WIDTH-bit operand
//   busy   out  high for the WIDTH scanning cycles
//   done   out  one-cycle pulse when out has just been updated
//   out    out  WIDTH-bit result, held until the next completion
module bit_scan_unit
    import bit_scan_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    // Bit counter wide enough to hold WIDTH; not a user parameter.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = '0;

    state_t           state;
    logic [WIDTH-1:0] sr;        // operand shift register, scanned from MSB
    logic [WIDTH-1:0] acc;       // running result
    logic [WIDTH-1:0] acc_nxt;
    logic [1:0]       mode_q;    // mode captured at the accepting edge
    logic [CW-1:0]    cnt;       // bits consumed so far
    logic             seen_one;  // CLZ: a 1 has already been scanned
    logic             seen_nxt;
    logic             b;         // bit under scan this cycle

    assign b = sr[WIDTH-1];

    // Per-bit accumulator step. Only meaningful in RUN; the FSM ignores it
    // elsewhere.
    always_comb begin
        acc_nxt  = acc;
        seen_nxt = seen_one;
        unique case (mode_q)
            // Each scanned bit enters at the top and moves down, so the
            // first (MSB) bit ends in acc[0] after WIDTH steps.
            MODE_REV: acc_nxt = {b, acc[WIDTH-1:1]};
            MODE_POP: acc_nxt = b ? acc + ONE : acc;
            MODE_CLZ: begin
                if (b)
                    seen_nxt = 1'b1;
                else if (!seen_one)
                    acc_nxt = acc + ONE;
            end
            MODE_PAR: acc_nxt = {ZERO[WIDTH-1:1], acc[0] ^ b};
            default:  acc_nxt = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
            acc      <= '0;
            sr       <= '0;
            cnt      <= '0;
            mode_q   <= MODE_REV;
            seen_one <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the RUN->DONE edge sets it.
            done <= 1'b0;
            unique case (state)
                S_RUN: begin
                    sr       <= sr << 1;
                    acc      <= acc_nxt;
                    seen_one <= seen_nxt;
                    cnt      <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        out   <= acc_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                // DONE behaves like IDLE for acceptance, giving back-to-back
                // operations one per WIDTH+1 cycles.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sr       <= in;
                        mode_q   <= mode;
                        acc      <= '0;
                        cnt      <= '0;
                        seen_one <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : bit_scan_unit

// File: tb/tb_bit_scan_unit.sv
// tb_bit_scan_unit
//   Directed bench for bit_scan_unit at WIDTH=4 and WIDTH=8. Expected
//   results are queued when an operation is started and popped when done
//   pulses.
module tb_bit_scan_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] opnd;
    logic       start4, start8;
    logic       busy4, done4, busy8, done8;
    logic [3:0] out4;
    logic [7:0] out8;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    bit_scan_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode),
        .in(opnd[3:0]), .busy(busy4), .done(done4), .out(out4)
    );

    bit_scan_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode),
        .in(opnd), .busy(busy8), .done(done8), .out(out8)
    );

    function automatic logic cur_busy(input bit w8);
        return w8 ? busy8 : busy4;
    endfunction

    function automatic logic cur_done(input bit w8);
        return w8 ? done8 : done4;
    endfunction

    function automatic logic [31:0] cur_out(input bit w8);
        return w8 ? {24'h0, out8} : {28'h0, out4};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive a request, push its expected result, and
    // return at the negedge after the accepting edge.
    task automatic kick(input bit w8, input logic [1:0] m, input logic [7:0] v,
                        input logic [31:0] exp, input string tag);
        if (w8) start8 = 1'b1; else start4 = 1'b1;
        mode = m;
        opnd = v;
        sb.push_back(exp);
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        chk({tag, " busy_after_accept"}, cur_busy(w8), 1);
        chk({tag, " done_low_after_accept"}, cur_done(w8), 0);
    endtask

    // Wait (bounded) for done, counting busy cycles observed from now on,
    // then compare out with the scoreboard head. Returns at the done negedge.
    task automatic wait_check(input bit w8, input int exp_busy, input string tag);
        int bc = 0;
        bit got = 0;
        logic [31:0] exp;
        for (int i = 0; i < 64; i++) begin
            if (cur_done(w8)) begin
                got = 1;
                break;
            end
            if (cur_busy(w8)) bc++;
            @(negedge clk);
        end
        chk({tag, " done_seen"}, 32'(got), 1);
        if (got) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            chk({tag, " out"}, cur_out(w8), exp);
            chk({tag, " busy_cycles"}, bc, exp_busy);
            chk({tag, " busy_low_in_done"}, cur_busy(w8), 0);
        end
    endtask

    initial begin
        int nd;
        rst_n  = 1'b0;
        start4 = 1'b1;
        start8 = 1'b0;
        mode   = 2'b01;
        opnd   = 8'h0F;

        // Reset held for two edges with a pending start
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst busy", busy4, 0);
            chk("rst done", done4, 0);
            chk("rst out", out4, 0);
        end
        chk("rst out8", out8, 0);
        rst_n  = 1'b1;
        start4 = 1'b0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done4 || busy4) nd++;
        end
        chk("post_rst no activity", nd, 0);

        // WIDTH=4 basic modes
        kick(0, 2'b01, 8'h0F, 32'h4, "pop15");
        wait_check(0, 4, "pop15");
        @(negedge clk);
        chk("pop15 done_drops", done4, 0);
        chk("pop15 out_held", out4, 4'h4);

        kick(0, 2'b00, 8'h01, 32'h8, "rev0001");
        wait_check(0, 4, "rev0001");
        @(negedge clk);
        kick(0, 2'b10, 8'h02, 32'h2, "clz0010");
        wait_check(0, 4, "clz0010");
        @(negedge clk);
        kick(0, 2'b10, 8'h00, 32'h4, "clz0");
        wait_check(0, 4, "clz0");
        @(negedge clk);

        // PAR with an ignored mid-run start, then back-to-back from DONE
        kick(0, 2'b11, 8'h07, 32'h1, "par0111");
        @(negedge clk);
        start4 = 1'b1;
        mode   = 2'b01;
        opnd   = 8'h00;
        @(negedge clk);
        start4 = 1'b0;
        wait_check(0, 2, "par0111");
        kick(0, 2'b00, 8'h0C, 32'h3, "rev1100_b2b");
        wait_check(0, 4, "rev1100_b2b");
        @(negedge clk);

        // Reset after two RUN edges aborts the operation
        start4 = 1'b1;
        mode   = 2'b01;
        opnd   = 8'h0F;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", busy4, 0);
        chk("abort done", done4, 0);
        chk("abort out", out4, 0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4) nd++;
        end
        chk("abort no_done", nd, 0);

        // WIDTH=8
        kick(1, 2'b01, 8'hFF, 32'h08, "w8 popFF");
        wait_check(1, 8, "w8 popFF");
        @(negedge clk);
        kick(1, 2'b10, 8'h01, 32'h07, "w8 clz01");
        wait_check(1, 8, "w8 clz01");
        @(negedge clk);
        kick(1, 2'b00, 8'hA1, 32'h85, "w8 revA1");
        wait_check(1, 8, "w8 revA1");
        @(negedge clk);
        chk("scoreboard empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_bit_scan_unit
